// File: rtl/overlay_pkg.sv
// overlay_pkg: shared definitions for the overlay mixer slice.
//   - colour constants in {R1,G1,B1,R0,G0,B0} packing
//   - fade FSM state encoding and the top fade level
//   - pin_pack(): maps {hs, vs, rgb6} onto the TinyTapeout VGA PMOD order
//     {hsync, B0, G0, R0, vsync, B1, G1, R1}
package overlay_pkg;

  localparam logic [5:0] BLACK = 6'b000000;
  localparam logic [5:0] GOLD  = 6'b110110;
  localparam logic [5:0] RED   = 6'b100100;

  localparam logic [2:0] LEVEL_MAX = 3'd4;

  typedef enum logic [1:0] {
    HIDDEN   = 2'd0,
    FADE_IN  = 2'd1,
    SHOWN    = 2'd2,
    FADE_OUT = 2'd3
  } fade_state_t;

  // rgb bit positions: [5]=R1 [4]=G1 [3]=B1 [2]=R0 [1]=G0 [0]=B0
  function automatic logic [7:0] pin_pack(input logic hs, input logic vs,
                                          input logic [5:0] rgb);
    return {hs, rgb[0], rgb[1], rgb[2], vs, rgb[3], rgb[4], rgb[5]};
  endfunction

endpackage

// File: rtl/overlay_mixer_fade.sv
// fade_ctrl: frame-synchronous fade controller for the overlay.
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   vsync_in     : vertical sync at pin polarity (active-low)
//   ov_en        : asynchronous overlay enable
//   fade_level   : current fade level 0..4
//   fade_busy    : high while fading in or out
//   fb           : single-cycle frame-boundary pulse (vsync falling edge)
module fade_ctrl
  import overlay_pkg::*;
#(
  parameter int FADE_FRAMES = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync_in,
  input  logic       ov_en,
  output logic [2:0] fade_level,
  output logic       fade_busy,
  output logic       fb
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_FRAMES - 1);

  logic             en_meta;
  logic             en_s;
  logic             vs_q;
  fade_state_t      state, state_nx;
  logic [2:0]       level, level_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  // Two-flop synchronizer for the enable, plus the previous vsync sample
  // used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_meta <= 1'b0;
      en_s    <= 1'b0;
      vs_q    <= 1'b1;
    end else begin
      en_meta <= ov_en;
      en_s    <= en_meta;
      vs_q    <= vsync_in;
    end
  end

  assign fb = vs_q & ~vsync_in;

  // Fade state, level and frame counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HIDDEN;
      level <= 3'd0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      level <= level_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic: everything moves only on a frame boundary so a frame
  // is always rendered at a single level. Level steps saturate at 0 and
  // LEVEL_MAX, which also covers a direction reversal at either end.
  always_comb begin
    state_nx = state;
    level_nx = level;
    cnt_nx   = cnt;
    if (fb) begin
      case (state)
        HIDDEN: begin
          if (en_s) begin
            state_nx = FADE_IN;
            cnt_nx   = '0;
          end
        end
        FADE_IN: begin
          if (!en_s) begin
            state_nx = FADE_OUT;
            cnt_nx   = '0;
          end else if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            level_nx = (level >= LEVEL_MAX - 3'd1) ? LEVEL_MAX : level + 3'd1;
            if (level_nx == LEVEL_MAX) state_nx = SHOWN;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        SHOWN: begin
          if (!en_s) begin
            state_nx = FADE_OUT;
            cnt_nx   = '0;
          end
        end
        FADE_OUT: begin
          if (en_s) begin
            state_nx = FADE_IN;
            cnt_nx   = '0;
          end else if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            level_nx = (level <= 3'd1) ? 3'd0 : level - 3'd1;
            if (level_nx == 3'd0) state_nx = HIDDEN;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = HIDDEN;
          level_nx = 3'd0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  assign fade_level = level;
  assign fade_busy  = (state == FADE_IN) || (state == FADE_OUT);

endmodule

// File: rtl/overlay_mixer.sv
// overlay_mixer: final pixel stage driving the VGA PMOD pins.
//   clk, rst_n          : pixel clock, asynchronous active-low reset
//   hsync_in, vsync_in  : syncs at pin polarity (active-low)
//   active_in           : visible-area flag
//   bg_rgb              : background colour {R1,G1,B1,R0,G0,B0}
//   ov_draw, ov_rgb     : overlay pixel valid and colour
//   ov_en               : asynchronous overlay enable
//   uo_out              : {hsync, B0, G0, R0, vsync, B1, G1, R1}, registered
//   fade_level          : current fade level 0..4
//   fade_busy           : high while fading
module overlay_mixer
  import overlay_pkg::*;
#(
  parameter int FADE_FRAMES = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       active_in,
  input  logic [5:0] bg_rgb,
  input  logic       ov_draw,
  input  logic [5:0] ov_rgb,
  input  logic       ov_en,
  output logic [7:0] uo_out,
  output logic [2:0] fade_level,
  output logic       fade_busy
);

  logic       fb;
  logic       hs_q;
  logic       pp;
  logic       lp;
  logic       line_edge;
  logic       dither;
  logic       sel;
  logic [5:0] colour;

  fade_ctrl #(
    .FADE_FRAMES(FADE_FRAMES),
    .CNT_W      (CNT_W)
  ) u_fade (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync_in  (vsync_in),
    .ov_en     (ov_en),
    .fade_level(fade_level),
    .fade_busy (fade_busy),
    .fb        (fb)
  );

  assign line_edge = hs_q & ~hsync_in;

  // Pixel and line parity form a 2x2 ordered-dither cell. Line parity is
  // cleared on the frame boundary (taking priority over a coincident line
  // edge) so every frame starts the pattern at the same phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b1;
      pp   <= 1'b0;
      lp   <= 1'b0;
    end else begin
      hs_q <= hsync_in;
      pp   <= active_in ? ~pp : 1'b0;
      if (fb)             lp <= 1'b0;
      else if (line_edge) lp <= ~lp;
    end
  end

  // Dither masks: 1/4, checkerboard, 3/4 of the 2x2 cell for levels 1..3.
  always_comb begin
    dither = 1'b0;
    case (fade_level)
      3'd0:    dither = 1'b0;
      3'd1:    dither = ~pp & ~lp;
      3'd2:    dither = ~(pp ^ lp);
      3'd3:    dither = ~(pp & lp);
      default: dither = 1'b1;
    endcase
  end

  assign sel    = ov_draw & dither;
  assign colour = active_in ? (sel ? ov_rgb : bg_rgb) : BLACK;

  // Colour and both syncs share one register so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) uo_out <= pin_pack(1'b1, 1'b1, BLACK);
    else        uo_out <= pin_pack(hsync_in, vsync_in, colour);
  end

endmodule

// File: tb/tb_overlay_mixer.sv
// tb_overlay_mixer: directed bench for overlay_mixer. Two instances share
// the stimulus: one with FADE_FRAMES=2 and one with FADE_FRAMES=1. A
// frame-level model predicts pins, level and busy every cycle.
module tb_overlay_mixer;
  import overlay_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hsync_in, vsync_in, active_in, ov_draw, ov_en;
  logic [5:0] bg_rgb, ov_rgb;
  logic [7:0] uo0, uo1;
  logic [2:0] lvl0, lvl1;
  logic       busy0, busy1;

  int nCompared = 0;
  int nMismatched = 0;
  int redCount = 0;

  typedef struct packed {
    logic [7:0] uo0;
    logic [7:0] uo1;
    logic [2:0] l0;
    logic [2:0] l1;
    logic       b0;
    logic       b1;
    logic       act;
  } expect_t;

  expect_t expq[$];

  // Model: mode 0=hidden 1=fading in 2=shown 3=fading out
  int  mMode[2];
  int  mLvl[2];
  int  mCnt[2];
  bit  enVal;
  bit  prevVs;
  logic [3:0] maskTab [0:4] = '{4'b0000, 4'b0001, 4'b1001, 4'b0111, 4'b1111};

  always #5 clk = ~clk;

  overlay_mixer #(.FADE_FRAMES(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .active_in(active_in), .bg_rgb(bg_rgb), .ov_draw(ov_draw), .ov_rgb(ov_rgb),
    .ov_en(ov_en), .uo_out(uo0), .fade_level(lvl0), .fade_busy(busy0)
  );

  overlay_mixer #(.FADE_FRAMES(1), .CNT_W(1)) dutFast (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .active_in(active_in), .bg_rgb(bg_rgb), .ov_draw(ov_draw), .ov_rgb(ov_rgb),
    .ov_en(ov_en), .uo_out(uo1), .fade_level(lvl1), .fade_busy(busy1)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] packPins(input logic hs, input logic vs, input logic [5:0] c);
    logic [7:0] p;
    p[7] = hs;   p[6] = c[0]; p[5] = c[1]; p[4] = c[2];
    p[3] = vs;   p[2] = c[3]; p[1] = c[4]; p[0] = c[5];
    return p;
  endfunction

  function automatic logic [5:0] unpackColour(input logic [7:0] p);
    return {p[0], p[1], p[2], p[4], p[5], p[6]};
  endfunction

  function automatic logic [5:0] expColour(input int lvl, input logic act,
      input logic [5:0] bg, input logic draw, input logic [5:0] ov,
      input logic pp, input logic lp);
    logic [3:0] m;
    m = maskTab[lvl];
    if (!act) return 6'd0;
    if (draw && m[{lp, pp}]) return ov;
    return bg;
  endfunction

  // Frame-boundary behaviour of the fade, stated as plain level arithmetic.
  task automatic modelFb(input int i, input int ff, input bit en);
    case (mMode[i])
      0: if (en) begin mMode[i] = 1; mCnt[i] = 0; end
      1: begin
        if (!en) begin mMode[i] = 3; mCnt[i] = 0; end
        else if (mCnt[i] == ff - 1) begin
          mCnt[i] = 0;
          mLvl[i] = (mLvl[i] + 1 > 4) ? 4 : mLvl[i] + 1;
          if (mLvl[i] == 4) mMode[i] = 2;
        end else mCnt[i] = mCnt[i] + 1;
      end
      2: if (!en) begin mMode[i] = 3; mCnt[i] = 0; end
      default: begin
        if (en) begin mMode[i] = 1; mCnt[i] = 0; end
        else if (mCnt[i] == ff - 1) begin
          mCnt[i] = 0;
          mLvl[i] = (mLvl[i] - 1 < 0) ? 0 : mLvl[i] - 1;
          if (mLvl[i] == 0) mMode[i] = 0;
        end else mCnt[i] = mCnt[i] + 1;
      end
    endcase
  endtask

  // Drive one pixel, predict the registered result, and queue it for the
  // compare process once the sampling edge has passed.
  task automatic applyStimulus(input logic hs, input logic vs, input logic act,
      input logic [5:0] bg, input logic draw, input logic [5:0] ov,
      input logic pp, input logic lp);
    expect_t e;
    hsync_in  = hs;
    vsync_in  = vs;
    active_in = act;
    bg_rgb    = bg;
    ov_draw   = draw;
    ov_rgb    = ov;
    e.uo0 = packPins(hs, vs, expColour(mLvl[0], act, bg, draw, ov, pp, lp));
    e.uo1 = packPins(hs, vs, expColour(mLvl[1], act, bg, draw, ov, pp, lp));
    if (prevVs && !vs) begin
      modelFb(0, 2, enVal);
      modelFb(1, 1, enVal);
    end
    prevVs = vs;
    e.l0  = 3'(mLvl[0]);
    e.l1  = 3'(mLvl[1]);
    e.b0  = (mMode[0] == 1) || (mMode[0] == 3);
    e.b1  = (mMode[1] == 1) || (mMode[1] == 3);
    e.act = act;
    @(posedge clk);
    expq.push_back(e);
    #1;
  endtask

  // Compare DUT against the model on every clocked cycle.
  always @(negedge clk) begin
    expect_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checkOutput("uo_out",      16'(uo0),   16'(e.uo0));
      checkOutput("uo_out_fast", 16'(uo1),   16'(e.uo1));
      checkOutput("level",       16'(lvl0),  16'(e.l0));
      checkOutput("level_fast",  16'(lvl1),  16'(e.l1));
      checkOutput("busy",        16'(busy0), 16'(e.b0));
      checkOutput("busy_fast",   16'(busy1), 16'(e.b1));
      if (e.act && unpackColour(uo0) == RED) redCount++;
    end
  end

  task automatic doReset();
    rst_n = 1'b0;
    expq.delete();
    mMode = '{0, 0};
    mLvl  = '{0, 0};
    mCnt  = '{0, 0};
    prevVs = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1; active_in = 1'b0;
    bg_rgb = BLACK; ov_rgb = BLACK; ov_draw = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One frame: 6 lines of 8 pixels; rows 0..3 carry a 4-pixel active span,
  // line 5 is the vsync line (its start is the frame boundary).
  task automatic runFrame(input bit draw, input bit glitch);
    redCount = 0;
    for (int line = 0; line < 6; line++) begin
      for (int c = 0; c < 8; c++) begin
        logic a;
        a = (line < 4) && (c >= 3) && (c < 7);
        ov_en = (glitch && line == 2 && c == 0) ? ~enVal : enVal;
        applyStimulus((c < 2) ? 1'b0 : 1'b1, (line == 5) ? 1'b0 : 1'b1, a,
                      GOLD, draw, RED, 1'((c - 3) & 1), 1'((line + 1) & 1));
      end
    end
    ov_en = enVal;
    @(negedge clk);
    #1;
  endtask

  int levelSeq [0:7] = '{0, 1, 1, 2, 2, 3, 3, 4};
  int redSeq   [0:3] = '{4, 8, 12, 16};

  initial begin
    enVal = 1'b0;
    ov_en = 1'b0;
    doReset();

    // Pin order and blanking straight after reset
    applyStimulus(1'b0, 1'b1, 1'b1, GOLD, 1'b0, RED, 1'b0, 1'b0);
    @(negedge clk); #1;
    checkOutput("pinOrder", 16'(uo0), 16'h3B);
    applyStimulus(1'b0, 1'b1, 1'b0, GOLD, 1'b1, RED, 1'b0, 1'b0);
    @(negedge clk); #1;
    checkOutput("blanking", 16'(uo0), 16'h08);
    applyStimulus(1'b1, 1'b1, 1'b1, RED, 1'b0, GOLD, 1'b0, 1'b0);
    rst_n = 1'b0;
    expq.delete();
    #1;
    checkOutput("resetMidLine", 16'(uo0), 16'h88);
    doReset();

    // Fade in with the dither density sampled at each level
    enVal = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      runFrame(1'b1, 1'b0);
      if (k >= 2 && k <= 9) checkOutput("fadeInLevel", 16'(lvl0), 16'(levelSeq[k - 2]));
      if (k % 2 == 0 && k >= 4) checkOutput("overlayCount", 16'(redCount), 16'(redSeq[k / 2 - 2]));
    end
    checkOutput("shownBusy", 16'(busy0), 16'h0);

    // One-cycle enable glitch between boundaries must not disturb SHOWN
    runFrame(1'b1, 1'b1);
    checkOutput("glitchLevel", 16'(lvl0), 16'h4);
    checkOutput("glitchBusy",  16'(busy0), 16'h0);

    // Fade out to level 3, then asynchronous reset without a clock edge
    enVal = 1'b0;
    repeat (3) runFrame(1'b0, 1'b0);
    checkOutput("fadeOutLevel3", 16'(lvl0), 16'h3);
    checkOutput("fadeOutBusy",   16'(busy0), 16'h1);
    rst_n = 1'b0;
    expq.delete();
    #1;
    checkOutput("asyncResetUo",    16'(uo0),  16'h88);
    checkOutput("asyncResetLevel", 16'(lvl0), 16'h0);
    checkOutput("asyncResetBusy",  16'(busy0), 16'h0);
    doReset();

    // Reversal in the middle of a fade in
    enVal = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      runFrame(1'b0, 1'b0);
      if (k == 5) begin
        checkOutput("revStartLevel", 16'(lvl0), 16'h2);
        checkOutput("revStartBusy",  16'(busy0), 16'h1);
      end
    end
    enVal = 1'b0;
    runFrame(1'b0, 1'b0);
    checkOutput("revTurnLevel", 16'(lvl0), 16'h2);
    checkOutput("revTurnBusy",  16'(busy0), 16'h1);
    repeat (4) runFrame(1'b0, 1'b0);
    checkOutput("revEndLevel", 16'(lvl0), 16'h0);
    checkOutput("revEndBusy",  16'(busy0), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
